pipe_addsub_acc: RTL and testbench

Parametrised pipelined arithmetic unit and successor to the single-cycle 16-bit registered adder. Adds width and latency parameters, a valid/ready handshake with backpressure, subtract and accumulate modes, optional saturation and an overflow flag. Sits in the datapath wherever a streamed two-operand sum or running total is needed.

---
 rtl/adder_pkg.sv | 15 +
 rtl/pipe_reg.sv | 25 ++
 rtl/pipe_addsub_acc.sv | 108 ++++++++++
 tb/tb_pipe_addsub_acc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract/accumulate unit:
// mode encodings and the result-width helper.
package adder_pkg;

  localparam logic [1:0] MODE_ADD      = 2'b00;
  localparam logic [1:0] MODE_SUB      = 2'b01;
  localparam logic [1:0] MODE_ACC      = 2'b10;
  localparam logic [1:0] MODE_ACC_LOAD = 2'b11;

  // Results carry one bit more than the operands so ADD can never overflow.
  function automatic int result_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// One retiming stage: a valid bit plus payload, advancing only when enabled.
module pipe_reg #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (en_i) begin
      valid_o <= valid_i;
      // Bubbles leave the payload untouched so the output only moves on real data.
      if (valid_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/pipe_addsub_acc.sv
// Pipelined two-operand add / subtract / accumulate unit with backpressure,
// optional saturation and a per-result overflow flag.
module pipe_addsub_acc
  import adder_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PIPE_STAGES = 2,
  parameter int SAT_EN      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            mode_i,
  input  logic [DATA_W-1:0]     data_1_i,
  input  logic [DATA_W-1:0]     data_2_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_W:0]       sum_o,
  output logic                  ovf_o
);

  localparam int RES_W = result_w(DATA_W);

  // Handshake: a transfer happens on a rising edge when valid and ready are
  // both 1. The whole pipe advances when the output slot is empty or being
  // drained (adv); upstream is ready exactly when the pipe advances.
  logic adv;
  logic accept;
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;
  assign accept  = valid_i & adv;

  logic [RES_W-1:0]  acc;
  logic [DATA_W+1:0] d1_ext;
  logic [DATA_W+1:0] d2_ext;
  logic [DATA_W+1:0] r_full;
  logic [RES_W-1:0]  r_out;
  logic              r_ovf;

  always_comb begin
    d1_ext = {2'b00, data_1_i};
    d2_ext = {2'b00, data_2_i};
    r_full = '0;
    r_out  = '0;
    r_ovf  = 1'b0;
    case (mode_i)
      MODE_ADD: begin
        r_full = d1_ext + d2_ext;
        r_out  = r_full[RES_W-1:0];
      end
      MODE_SUB: begin
        r_full = d1_ext - d2_ext;
        r_ovf  = (data_1_i < data_2_i);
        r_out  = (r_ovf && SAT_EN != 0) ? '0 : r_full[RES_W-1:0];
      end
      MODE_ACC: begin
        r_full = {1'b0, acc} + d1_ext + d2_ext;
        r_ovf  = r_full[RES_W];
        r_out  = (r_ovf && SAT_EN != 0) ? {RES_W{1'b1}} : r_full[RES_W-1:0];
      end
      default: begin
        r_full = d1_ext + d2_ext;
        r_out  = r_full[RES_W-1:0];
      end
    endcase
  end

  logic             s1_valid;
  logic [RES_W:0]   s1_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      acc      <= '0;
    end else begin
      if (adv) begin
        s1_valid <= accept;
        if (accept) s1_data <= {r_ovf, r_out};
      end
      if (accept && (mode_i == MODE_ACC || mode_i == MODE_ACC_LOAD)) acc <= r_out;
    end
  end

  // Stage payload is {ovf, sum}; element 0 is the arithmetic stage.
  logic           stg_valid [PIPE_STAGES];
  logic [RES_W:0] stg_data  [PIPE_STAGES];

  assign stg_valid[0] = s1_valid;
  assign stg_data[0]  = s1_data;

  for (genvar g = 1; g < PIPE_STAGES; g++) begin : g_retime
    pipe_reg #(.W(RES_W + 1)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (adv),
      .valid_i (stg_valid[g-1]),
      .data_i  (stg_data[g-1]),
      .valid_o (stg_valid[g]),
      .data_o  (stg_data[g])
    );
  end

  assign valid_o        = stg_valid[PIPE_STAGES-1];
  assign {ovf_o, sum_o} = stg_data[PIPE_STAGES-1];

endmodule

// File: tb/tb_pipe_addsub_acc.sv
// Directed bench for pipe_addsub_acc: a wrapping and a saturating instance
// share one stimulus stream and are checked against hand-computed results.
module tb_pipe_addsub_acc;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  mode_i;
  logic [15:0] data_1_i;
  logic [15:0] data_2_i;
  logic        ready_i;

  logic        ready_o,   ready_s;
  logic        valid_o,   valid_s;
  logic [16:0] sum_o,     sum_s;
  logic        ovf_o,     ovf_s;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_sat_q[$];
  logic [17:0] held;
  bit          stalled_prev = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_addsub_acc #(.DATA_W(16), .PIPE_STAGES(2), .SAT_EN(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .data_1_i(data_1_i), .data_2_i(data_2_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o), .ovf_o(ovf_o)
  );

  pipe_addsub_acc #(.DATA_W(16), .PIPE_STAGES(2), .SAT_EN(1)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_s),
    .mode_i(mode_i), .data_1_i(data_1_i), .data_2_i(data_2_i),
    .valid_o(valid_s), .ready_i(ready_i), .sum_o(sum_s), .ovf_o(ovf_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; everything is sampled on
  // the falling edge, where a handshake seen there completes on the next rise.
  task automatic send(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                      input logic [17:0] e0, input logic [17:0] e1, input bit track);
    int n = 0;
    mode_i = m; data_1_i = a; data_2_i = b; valid_i = 1'b1;
    if (track) begin
      exp_q.push_back(e0);
      exp_sat_q.push_back(e1);
    end
    @(negedge clk);
    while (!ready_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) check_eq("accept_timeout", 32'd0, 32'd1);
    last_acc_cyc = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_sat_q.size() != 0) && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check_eq("drain", exp_q.size() + exp_sat_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) check_eq("extra_out", 32'd1, 32'd0);
      else check_eq("out_wrap", {ovf_o, sum_o}, exp_q.pop_front());
    end
    if (!rst_i && valid_s && ready_i) begin
      if (exp_sat_q.size() == 0) check_eq("extra_out_sat", 32'd1, 32'd0);
      else check_eq("out_sat", {ovf_s, sum_s}, exp_sat_q.pop_front());
    end
    if (!rst_i && valid_o && !ready_i) begin
      check_eq("stall_ready", ready_o, 1'b0);
      if (stalled_prev) check_eq("stall_hold", {ovf_o, sum_o}, held);
      held = {ovf_o, sum_o};
      stalled_prev = 1;
    end else begin
      stalled_prev = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_i = 1'b1; valid_i = 1'b0; mode_i = ADD; data_1_i = '0; data_2_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_sum", {ovf_o, sum_o}, 18'h0);
    check_eq("rst_ready", ready_o, 1'b1);
    @(posedge clk); #1;

    // ADD at the top of the operand range, with latency measurement
    send(ADD, 16'hFFFF, 16'h0001, 18'h10000, 18'h10000, 1);
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_eq("latency", cyc - last_acc_cyc, 32'd2);
    drain();

    // SUB underflow wraps or clamps; in-range SUB is exact
    send(SUB, 16'd5, 16'd7, 18'h3FFFE, 18'h20000, 1);
    send(SUB, 16'd7, 16'd5, 18'h00002, 18'h00002, 1);
    drain();

    // Accumulate with an interleaved ADD that must not disturb the total
    send(LOAD, 16'd10, 16'd20, 18'd30, 18'd30, 1);
    send(ACC,  16'd5,  16'd0,  18'd35, 18'd35, 1);
    send(ADD,  16'd1,  16'd1,  18'd2,  18'd2,  1);
    send(ACC,  16'd1,  16'd1,  18'd37, 18'd37, 1);
    drain();

    // Accumulator overflow
    send(LOAD, 16'hFFFF, 16'hFFFF, 18'h1FFFE, 18'h1FFFE, 1);
    send(ACC,  16'd2,    16'd0,    18'h20000, 18'h3FFFF, 1);
    drain();

    // Backpressure: 4 back-to-back ADDs, ready_i low for 3 cycles mid-stream
    fork
      begin
        send(ADD, 16'd1,    16'd2,    18'h00003, 18'h00003, 1);
        send(ADD, 16'd100,  16'd200,  18'h0012C, 18'h0012C, 1);
        send(ADD, 16'h8000, 16'h8000, 18'h10000, 18'h10000, 1);
        send(ADD, 16'h1234, 16'h1111, 18'h02345, 18'h02345, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();

    // Reset with two results in flight and accumulator at 35
    send(LOAD, 16'd10, 16'd20, 18'd30, 18'd30, 1);
    send(ACC,  16'd5,  16'd0,  18'd35, 18'd35, 1);
    drain();
    ready_i = 1'b0;
    send(ADD, 16'd3, 16'd4, 18'd0, 18'd0, 0);
    send(ADD, 16'd5, 16'd6, 18'd0, 18'd0, 0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", valid_o, 1'b0);
    check_eq("midrst_sum", {ovf_o, sum_o}, 18'h0);
    check_eq("midrst_valid_sat", valid_s, 1'b0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(ACC, 16'd1, 16'd0, 18'd1, 18'd1, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
